// File: rtl/rr_stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package rr_stream_mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Index following g in a ring of n channels; handles non-power-of-two n.
   function automatic int unsigned next_idx(input int unsigned g, input int unsigned n);
      return (g + 1 >= n) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/rr_stream_mux_mux.sv
// Combinational N-to-1 word selector driven by a one-hot grant, built from 2:1 muxes.
module mux_2_to_1 #(
   parameter int unsigned Bit = 16
) (
   input  logic           sel_i,
   input  logic [Bit-1:0] a_i,
   input  logic [Bit-1:0] b_i,
   output logic [Bit-1:0] y_o
);
   assign y_o = sel_i ? b_i : a_i;
endmodule

module mux_n_to_1 #(
   parameter int unsigned Bit = 16,
   parameter int unsigned N   = 4
) (
   input  logic [N-1:0]     grant_i,
   input  logic [N*Bit-1:0] data_i,
   output logic [Bit-1:0]   data_o
);
   localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned NP    = 1 << SEL_W;

   logic [SEL_W-1:0]           sel_c;
   logic [2*NP-2:0][Bit-1:0]   node;

   // One-hot to binary; an all-zero grant selects channel 0, which is never loaded.
   always_comb begin
      sel_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant_i[i]) sel_c = sel_c | SEL_W'(i);
      end
   end

   // Heap-ordered tree: leaves at NP-1.., node k takes children 2k+1 (low) and 2k+2 (high).
   for (genvar j = 0; j < NP; j++) begin : g_leaf
      if (j < N) begin : g_used
         assign node[NP-1+j] = data_i[j*Bit +: Bit];
      end else begin : g_pad
         assign node[NP-1+j] = '0;
      end
   end

   for (genvar k = 0; k < NP-1; k++) begin : g_node
      localparam int unsigned D = $clog2(k + 2) - 1;
      mux_2_to_1 #(.Bit(Bit)) u_mux2 (
         .sel_i (sel_c[SEL_W-1-D]),
         .a_i   (node[2*k+1]),
         .b_i   (node[2*k+2]),
         .y_o   (node[k])
      );
   end

   assign data_o = node[0];
endmodule

// File: rtl/rr_stream_mux.sv
// Registered N-to-1 valid/ready stream mux with run-time fixed-priority or round-robin arbitration.
module rr_stream_mux
   import rr_stream_mux_pkg::*;
#(
   parameter int unsigned Bit   = 16,
   parameter int unsigned N     = 4,
   parameter int unsigned SEL_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic [N-1:0]     in_valid,
   input  logic [N*Bit-1:0] in_data,
   output logic [N-1:0]     in_ready,
   output logic             out_valid,
   output logic [Bit-1:0]   out_data,
   output logic [SEL_W-1:0] out_ch,
   input  logic             out_ready
);

   logic             out_valid_q, out_valid_d;
   logic [Bit-1:0]   out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_ch_q,    out_ch_d;
   logic [SEL_W-1:0] ptr_q,       ptr_d;

   logic [N-1:0]     grant_c;
   logic [SEL_W-1:0] gidx_c;
   logic             found_c;
   logic             can_load_c;
   logic             accept_c;
   logic [Bit-1:0]   sel_data_c;
   int unsigned      j_c;

   // Search starts at ptr in round-robin mode, at channel 0 in fixed mode.
   always_comb begin
      grant_c = '0;
      gidx_c  = '0;
      found_c = 1'b0;
      j_c     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j_c = (mode == MODE_RR) ? 32'(ptr_q) + k : k;
         if (j_c >= N) j_c = j_c - N;
         if (!found_c && in_valid[SEL_W'(j_c)]) begin
            grant_c[SEL_W'(j_c)] = 1'b1;
            gidx_c               = SEL_W'(j_c);
            found_c              = 1'b1;
         end
      end
   end

   assign can_load_c = !out_valid_q || out_ready;
   assign accept_c   = found_c && can_load_c;
   assign in_ready   = rst ? '0 : (grant_c & {N{can_load_c}});

   mux_n_to_1 #(.Bit(Bit), .N(N)) u_sel (
      .grant_i (grant_c),
      .data_i  (in_data),
      .data_o  (sel_data_c)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
      if (accept_c) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data_c;
         out_ch_d    = gidx_c;
         if (mode == MODE_RR) ptr_d = SEL_W'(next_idx(32'(gidx_c), N));
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule
